keypad_responder: RTL and testbench
===================================

# keypad_responder

Synthesizable 4x4 matrix-keypad responder: the device end of the keypad scan interface whose initiator drives `col` and samples `row`. It accepts key codes over a valid/ready handshake and presents each one as a physical key closure: contact bounce, a hold, release bounce, then an inter-key gap. It sits between a stimulus or test-sequencer source and any keypad scanner in the safe-box design, for on-board self-test and bench use.

## Interface
- `BOUNCE_CYCLES`, default 8: length of each bounce phase in clk cycles; 0 skips both bounce phases.
- `PRESS_CYCLES`, default 500000: length of the stable-closed hold, must be ≥1.
- `GAP_CYCLES`, default 500000: length of the stable-open time after release, must be ≥1.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `key_valid`  in  1  source has a key code.
- `key_code`  in  4  key index = row*4 + column (row 0..3, column 0..3).
- `key_ready`  out  1  responder can accept a code.
- `col`  in  4  column strobes from the scanner, active-low.
- `row`  out  4  row returns, active-low, idle 4'hF.
- `busy`  out  1  a key sequence is in progress.
- `key_done`  out  1  one-cycle pulse when a sequence completes.

## Operation
- Handshake: a transfer occurs on a rising clk edge where `key_valid & key_ready`. `key_code` is latched there.
- `key_ready = (state==IDLE) & ~rst`. The source must hold `key_valid` and `key_code` until the transfer. There is no queue; a second code waits in the source.
- States: IDLE → BOUNCE_IN → HOLD → BOUNCE_OUT → GAP → IDLE.
  - If `BOUNCE_CYCLES==0`: IDLE → HOLD and HOLD → GAP.
- Registered `contact` flag:
  - BOUNCE_IN: closed in its first cycle, then toggles every cycle.
  - HOLD: closed.
  - BOUNCE_OUT: open in its first cycle, then toggles every cycle.
  - GAP and IDLE: open.
- Row drive (combinational from `col`, `contact`, latched code):
  - `row[r]` = 0 iff `contact` is closed, r = code[3:2], and `col[code[1:0]]` = 0.
  - All other row bits are 1.
  - Multiple low columns are legal; only the latched column matters.
- `busy` = 1 in every state except IDLE.
- `key_done` pulses exactly once, in the first IDLE cycle after GAP.
- Phase counter: one down-counter, width = clog2 of the largest parameter + 1. It loads phase length − 1 on entry and the phase exits at 0.

## Timing
- Reset values while `rst` is high and after release: state IDLE, contact open, `row`=4'hF, `busy`=0, `key_done`=0, `key_ready`=0 during reset then 1.
- Acceptance edge is T0.
- BOUNCE_IN occupies cycles T0+1 .. T0+B. B = `BOUNCE_CYCLES`, P = `PRESS_CYCLES`, G = `GAP_CYCLES`.
- HOLD occupies B+1 .. B+P.
- BOUNCE_OUT occupies B+P+1 .. 2B+P.
- GAP occupies 2B+P+1 .. 2B+P+G.
- `key_done` and `key_ready` are high at cycle 2B+P+G+1. A new transfer is possible on that same edge, giving back-to-back keys.
- `row` responds to `col` with zero clk latency (combinational), as a real matrix does.
- Reset mid-sequence: contact opens at once, `row`=4'hF, no `key_done`, latched code discarded.
- `key_valid` asserted while busy: ignored and not acknowledged.
- `key_code` changing while busy has no effect.

## Structure
- Package `keypad_pkg`:
  - state enum;
  - functions `code_row(code)` and `code_col(code)`;
  - localparam `ROW_IDLE = 4'hF`.
- One natural sub-module, `keypad_phase_timer`: a loadable down-counter with a zero flag.
- FSM, contact flag and row logic stay in the top block.

## Test plan
Parameters for all scenarios: B=4, P=16, G=8.
- **Basic press:** send code 4'h6 (row 1, col 2). Scanner drives `col`=4'b1011 every cycle. `row` is 4'b1101 on exactly the 16 HOLD cycles plus the closed bounce cycles, and 4'hF otherwise. `key_done` pulses at T0+33.
- **Wrong column:** send code 4'h6. Scanner drives `col`=4'b1101 throughout. `row` stays 4'hF for the whole sequence.
- **Bounce pattern:** send code 4'h0 with `col`=4'h0. `row[0]` in T0+1..T0+4 reads 0,1,0,1. In T0+21..T0+24 it reads 1,0,1,0.
- **Back-to-back:** codes 4'hF then 4'h5 held valid. The second transfer occurs at T0+33 with no idle gap. There are exactly two `key_done` pulses.
- **Ignored while busy:** toggle `key_valid` during HOLD. There is no acceptance and the sequence is unchanged.
- **Reset mid-HOLD:** assert `rst` at T0+10. `row` becomes 4'hF immediately, `busy`=0, and no `key_done`. After release, `key_ready`=1 and a new code is accepted normally.
- **B=0 variant:** send code 4'h3. The hold starts at T0+1 and `key_done` pulses at T0+25.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad responder: FSM states, code field
// extraction and the idle row pattern.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BOUNCE_IN,
        ST_HOLD,
        ST_BOUNCE_OUT,
        ST_GAP
    } state_e;

    localparam logic [3:0] ROW_IDLE = 4'hF;

    function automatic logic [1:0] code_row(input logic [3:0] code);
        return code[3:2];
    endfunction

    function automatic logic [1:0] code_col(input logic [3:0] code);
        return code[1:0];
    endfunction

endpackage

// File: rtl/keypad_phase_timer.sv
// Loadable down-counter shared by every timed phase; parks at zero and
// flags it so the FSM knows the current phase has run its length.
module keypad_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/keypad_responder.sv
// Device end of a 4x4 keypad scan: turns each accepted key code into a
// bounced press, hold, bounced release and inter-key gap on the row lines.
module keypad_responder
    import keypad_pkg::*;
#(
    parameter int BOUNCE_CYCLES = 8,
    parameter int PRESS_CYCLES  = 500000,
    parameter int GAP_CYCLES    = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic       busy,
    output logic       key_done
);

    localparam int MAX_BP = (BOUNCE_CYCLES > PRESS_CYCLES) ? BOUNCE_CYCLES : PRESS_CYCLES;
    localparam int MAX_P  = (MAX_BP > GAP_CYCLES) ? MAX_BP : GAP_CYCLES;
    localparam int CW     = $clog2(MAX_P) + 1;

    localparam bit          HAS_BOUNCE = (BOUNCE_CYCLES > 0);
    localparam logic [CW-1:0] B_LD = CW'(HAS_BOUNCE ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [CW-1:0] P_LD = CW'(PRESS_CYCLES - 1);
    localparam logic [CW-1:0] G_LD = CW'(GAP_CYCLES - 1);

    state_e        state_q;
    logic          contact_q;
    logic [3:0]    code_q;
    logic          done_q;
    logic          accept;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_zero;

    assign key_ready = (state_q == ST_IDLE) & ~rst;
    assign accept    = key_valid & key_ready;
    assign busy      = (state_q != ST_IDLE);
    assign key_done  = done_q;

    // Each phase loads its length minus one on entry and exits when the timer reads zero.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: if (accept) begin
                tmr_load = 1'b1;
                tmr_val  = HAS_BOUNCE ? B_LD : P_LD;
            end
            ST_BOUNCE_IN: if (tmr_zero) begin
                tmr_load = 1'b1;
                tmr_val  = P_LD;
            end
            ST_HOLD: if (tmr_zero) begin
                tmr_load = 1'b1;
                tmr_val  = HAS_BOUNCE ? B_LD : G_LD;
            end
            ST_BOUNCE_OUT: if (tmr_zero) begin
                tmr_load = 1'b1;
                tmr_val  = G_LD;
            end
            default: ;
        endcase
    end

    keypad_phase_timer #(.W(CW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .zero_o (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            contact_q <= 1'b0;
            code_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (accept) begin
                    code_q    <= key_code;
                    contact_q <= 1'b1;
                    state_q   <= HAS_BOUNCE ? ST_BOUNCE_IN : ST_HOLD;
                end
                ST_BOUNCE_IN: begin
                    if (tmr_zero) begin
                        state_q   <= ST_HOLD;
                        contact_q <= 1'b1;
                    end else begin
                        contact_q <= ~contact_q;
                    end
                end
                ST_HOLD: if (tmr_zero) begin
                    state_q   <= HAS_BOUNCE ? ST_BOUNCE_OUT : ST_GAP;
                    contact_q <= 1'b0;
                end
                ST_BOUNCE_OUT: begin
                    if (tmr_zero) begin
                        state_q   <= ST_GAP;
                        contact_q <= 1'b0;
                    end else begin
                        contact_q <= ~contact_q;
                    end
                end
                ST_GAP: if (tmr_zero) begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A closed contact shorts the latched row to the latched column only while that column is strobed.
    always_comb begin
        row = ROW_IDLE;
        if (contact_q && !col[code_col(code_q)]) begin
            row[code_row(code_q)] = 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_responder.sv
// Scoreboard bench for keypad_responder: stimulus queues per-cycle expected
// outputs, negedge monitors pop and compare.
module tb_keypad_responder;

    localparam int B = 4;
    localparam int P = 16;
    localparam int G = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic       v0 = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [3:0] col = 4'hF;
    logic       key_ready, busy, key_done;
    logic       rdy0, busy0, done0;
    logic [3:0] row, row0;

    always #5 clk = ~clk;

    keypad_responder #(.BOUNCE_CYCLES(B), .PRESS_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .col(col), .row(row), .busy(busy), .key_done(key_done)
    );

    keypad_responder #(.BOUNCE_CYCLES(0), .PRESS_CYCLES(P), .GAP_CYCLES(G)) dut0 (
        .clk(clk), .rst(rst), .key_valid(v0), .key_code(key_code),
        .key_ready(rdy0), .col(col), .row(row0), .busy(busy0), .key_done(done0)
    );

    typedef struct {
        logic [6:0] vec;   // {row, busy, done, ready}
        int         scen;
        int         k;
    } exp_t;

    exp_t q[$];
    exp_t q0[$];
    int   checks = 0;
    int   fails  = 0;
    int   ndone  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", nm, act, expv);
        end
    endtask

    function automatic logic closed(input int k, input int b);
        if (k <= b)         return ((k - 1) % 2) == 0;
        if (k <= b + P)     return 1'b1;
        if (k <= 2 * b + P) return ((k - b - P - 1) % 2) == 1;
        return 1'b0;
    endfunction

    task automatic push(input int inst, input int scen, input int k, input logic [3:0] r,
                        input logic bz, input logic dn, input logic rd);
        exp_t e;
        e.vec  = {r, bz, dn, rd};
        e.scen = scen;
        e.k    = k;
        if (inst != 0) q0.push_back(e);
        else           q.push_back(e);
    endtask

    task automatic setv(input int inst, input logic v);
        if (inst != 0) v0 = v;
        else           key_valid = v;
    endtask

    // Presents a code at posedge+1; returns in the cycle where key_done is expected.
    task automatic send_key(input int inst, input int scen, input logic [3:0] code,
                            input logic [3:0] colv, input logic [3:0] hrow,
                            input logic pre_done, input logic keep, input logic tog);
        int b;
        int n;
        b = (inst != 0) ? 0 : B;
        n = 2 * b + P + G;
        key_code = code;
        col      = colv;
        setv(inst, 1'b1);
        push(inst, scen, 0, 4'hF, 1'b0, pre_done, 1'b1);
        for (int k = 1; k <= n; k++)
            push(inst, scen, k, closed(k, b) ? hrow : 4'hF, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        for (int k = 1; k <= n; k++) begin
            if (tog && k > b && k <= b + P) begin
                setv(inst, k[0]);
                key_code = code ^ 4'hA;
            end else begin
                setv(inst, keep);
                key_code = code;
            end
            @(posedge clk); #1;
        end
        setv(inst, 1'b0);
        key_code = code;
    endtask

    task automatic idle(input int inst, input int scen, input int n, input logic first_done);
        for (int i = 0; i < n; i++)
            push(inst, scen, 100 + i, 4'hF, 1'b0, (i == 0) ? first_done : 1'b0, 1'b1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("s%0d_k%0d", e.scen, e.k), {25'd0, row, busy, key_done, key_ready},
                {25'd0, e.vec});
        end
    end

    always @(negedge clk) begin : mon0
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk($sformatf("b0_s%0d_k%0d", e.scen, e.k), {25'd0, row0, busy0, done0, rdy0},
                {25'd0, e.vec});
        end
    end

    always @(negedge clk) if (key_done) ndone++;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // reset state: ready held low while rst is high
        push(0, 0, 0, 4'hF, 1'b0, 1'b0, 1'b0);
        push(0, 0, 1, 4'hF, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(0, 0, 2, 1'b0);

        // basic press, code 6 = row 1 col 2
        send_key(0, 1, 4'h6, 4'b1011, 4'b1101, 1'b0, 1'b0, 1'b0);
        idle(0, 1, 2, 1'b1);
        // wrong column strobed
        send_key(0, 2, 4'h6, 4'b1101, 4'hF, 1'b0, 1'b0, 1'b0);
        idle(0, 2, 2, 1'b1);
        // bounce pattern, all columns low
        send_key(0, 3, 4'h0, 4'b0000, 4'b1110, 1'b0, 1'b0, 1'b0);
        idle(0, 3, 2, 1'b1);
        // back-to-back with valid held high through the first sequence
        send_key(0, 4, 4'hF, 4'b0111, 4'b0111, 1'b0, 1'b1, 1'b0);
        send_key(0, 4, 4'h5, 4'b1101, 4'b1101, 1'b1, 1'b0, 1'b0);
        idle(0, 4, 2, 1'b1);
        // valid and code toggled during HOLD
        send_key(0, 5, 4'h9, 4'b1101, 4'b1011, 1'b0, 1'b0, 1'b1);
        idle(0, 5, 2, 1'b1);

        // reset mid-HOLD at T0+10
        key_code  = 4'h6;
        col       = 4'b1011;
        key_valid = 1'b1;
        push(0, 6, 0, 4'hF, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 9; k++)
            push(0, 6, k, closed(k, B) ? 4'b1101 : 4'hF, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        key_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_row", {28'd0, row}, 32'hF);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, key_done}, 32'd0);
        chk("rst_ready", {31'd0, key_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(0, 6, 3, 1'b0);
        send_key(0, 7, 4'hA, 4'b1011, 4'b1011, 1'b0, 1'b0, 1'b0);
        idle(0, 7, 2, 1'b1);

        // no-bounce instance, code 3 = row 0 col 3
        send_key(1, 8, 4'h3, 4'b0111, 4'b1110, 1'b0, 1'b0, 1'b0);
        idle(1, 8, 2, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        chk("done_pulses", ndone, 32'd7);
        chk("queues_drained", q.size() + q0.size(), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
